// File: rtl/biquad_coef_loader.sv
// Coefficient bank plus CSR write sequencer for the biquad cascade (address word, data word, gap; then per-stage commits).
// Optional COEF_LOADER_NEGATE_A_EN: slots 3/4 hold a2/a1 and are sent negated with saturation.
module biquad_coef_loader #(
  parameter int STAGES            = 2,
  parameter int COEFFICIENT_WIDTH = 25,
  parameter int STAGE_BITS        = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrEnable,
  input  logic [STAGE_BITS-1:0]        wrStage,
  input  logic [2:0]                   wrIndex,
  input  logic [COEFFICIENT_WIDTH-1:0] wrData,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         csrStrobe,
  output logic [31:0]                  GPIO_OUT
);

  localparam int CW = COEFFICIENT_WIDTH;
  localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(STAGES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, GAP, FIN} state_t;

  state_t                state_r;
  logic                  commit_r;
  logic [STAGE_BITS-1:0] stage_r;
  logic [2:0]            slot_r;
  logic [CW-1:0]         bank_r [STAGES][5];

  logic [CW-1:0]         coef_s;
  logic [STAGE_BITS-1:0] next_stage_s;
  logic [2:0]            next_slot_s;
  logic                  next_commit_s;
  logic                  last_s;

`ifdef COEF_LOADER_NEGATE_A_EN
  function automatic logic [CW-1:0] neg_sat(input logic [CW-1:0] v);
    logic [CW-1:0] most_neg;
    most_neg = {1'b1, {(CW-1){1'b0}}};
    if (v == most_neg) return ~most_neg;
    else return ~v + {{(CW-1){1'b0}}, 1'b1};
  endfunction
`endif

  function automatic logic [31:0] addr_word(input logic [STAGE_BITS-1:0] stg, input logic [2:0] slt);
    return {{(29-STAGE_BITS){1'b0}}, stg, slt};
  endfunction

  function automatic logic [31:0] data_word(input logic [CW-1:0] c);
    return {1'b1, 31'(c)};
  endfunction

  // Host writes into the bank; dropped while busy or when the slot/stage is out of range.
  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (wrEnable && !busy && wrStage == STAGE_BITS'(s)) begin
        case (wrIndex)
          3'd0:    bank_r[s][0] <= wrData;
          3'd1:    bank_r[s][1] <= wrData;
          3'd2:    bank_r[s][2] <= wrData;
          3'd3:    bank_r[s][3] <= wrData;
          3'd4:    bank_r[s][4] <= wrData;
          default: ;
        endcase
      end
    end
  end

  // Coefficient for the current stage/slot as it goes on the wire.
  always_comb begin
    coef_s = {CW{1'b0}};
    for (int s = 0; s < STAGES; s++) begin
      if (stage_r == STAGE_BITS'(s)) begin
        case (slot_r)
          3'd0:    coef_s = bank_r[s][0];
          3'd1:    coef_s = bank_r[s][1];
          3'd2:    coef_s = bank_r[s][2];
`ifdef COEF_LOADER_NEGATE_A_EN
          3'd3:    coef_s = neg_sat(bank_r[s][3]);
          3'd4:    coef_s = neg_sat(bank_r[s][4]);
`else
          3'd3:    coef_s = bank_r[s][3];
          3'd4:    coef_s = bank_r[s][4];
`endif
          default: coef_s = {CW{1'b0}};
        endcase
      end else begin
        coef_s = coef_s;
      end
    end
  end

  // Counter advance: slots stage-major, then one commit per stage; terminal compares only.
  always_comb begin
    next_stage_s  = stage_r;
    next_slot_s   = slot_r;
    next_commit_s = commit_r;
    last_s        = 1'b0;
    if (!commit_r) begin
      if (slot_r != 3'd4) begin
        next_slot_s = slot_r + 3'd1;
      end else if (stage_r != LAST_STAGE) begin
        next_stage_s = stage_r + STAGE_BITS'(1);
        next_slot_s  = 3'd0;
      end else begin
        next_commit_s = 1'b1;
        next_stage_s  = {STAGE_BITS{1'b0}};
        next_slot_s   = 3'd7;
      end
    end else begin
      if (stage_r != LAST_STAGE) begin
        next_stage_s = stage_r + STAGE_BITS'(1);
      end else begin
        last_s = 1'b1;
      end
    end
  end

  // Sequencer with outputs registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      csrStrobe <= 1'b0;
      GPIO_OUT  <= 32'd0;
      commit_r  <= 1'b0;
      stage_r   <= {STAGE_BITS{1'b0}};
      slot_r    <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r   <= ADDR;
            busy      <= 1'b1;
            csrStrobe <= 1'b1;
            GPIO_OUT  <= addr_word({STAGE_BITS{1'b0}}, 3'd0);
            commit_r  <= 1'b0;
            stage_r   <= {STAGE_BITS{1'b0}};
            slot_r    <= 3'd0;
          end else begin
            busy      <= 1'b0;
            csrStrobe <= 1'b0;
            GPIO_OUT  <= 32'd0;
          end
        end
        ADDR: begin
          state_r   <= DATA;
          csrStrobe <= 1'b1;
          GPIO_OUT  <= commit_r ? 32'h8000_0000 : data_word(coef_s);
        end
        DATA: begin
          state_r   <= GAP;
          csrStrobe <= 1'b0;
          GPIO_OUT  <= 32'd0;
        end
        GAP: begin
          stage_r  <= next_stage_s;
          slot_r   <= next_slot_s;
          commit_r <= next_commit_s;
          if (last_s) begin
            state_r   <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            csrStrobe <= 1'b0;
            GPIO_OUT  <= 32'd0;
          end else begin
            state_r   <= ADDR;
            csrStrobe <= 1'b1;
            GPIO_OUT  <= addr_word(next_stage_s, next_slot_s);
          end
        end
        FIN: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          csrStrobe <= 1'b0;
          GPIO_OUT  <= 32'd0;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          csrStrobe <= 1'b0;
          GPIO_OUT  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Bench for biquad_coef_loader: per-cycle queue model of the CSR stream, a filter-side CSR decoder, directed and random phases.
module tb_biquad_coef_loader;
  localparam int STAGES = 2;
  localparam int CW     = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrEnable = 1'b0;
  logic [2:0]    wrStage = 3'd0;
  logic [2:0]    wrIndex = 3'd0;
  logic [CW-1:0] wrData = '0;
  logic          start = 1'b0;
  logic          busy, done, csrStrobe;
  logic [31:0]   GPIO_OUT;

  biquad_coef_loader #(.STAGES(STAGES), .COEFFICIENT_WIDTH(CW), .STAGE_BITS(3)) dut (
    .clk(clk), .rst(rst), .wrEnable(wrEnable), .wrStage(wrStage), .wrIndex(wrIndex),
    .wrData(wrData), .start(start), .busy(busy), .done(done),
    .csrStrobe(csrStrobe), .GPIO_OUT(GPIO_OUT)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        strobe;
    logic [31:0] gpio;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t          q[$];
  exp_t          cur = '0;
  bit            model_live = 1'b0;
  logic [CW-1:0] mbank [STAGES][5];

  // Value the filter must receive for a bank entry, from plain signed arithmetic.
  function automatic logic [CW-1:0] tx_val(input logic [CW-1:0] v, input int slot);
    longint x;
    x = v[CW-1] ? longint'(v) - (longint'(1) << CW) : longint'(v);
`ifdef COEF_LOADER_NEGATE_A_EN
    if (slot >= 3) begin
      x = -x;
      if (x > (longint'(1) << (CW-1)) - 1) x = (longint'(1) << (CW-1)) - 1;
    end
`endif
    return CW'(x);
  endfunction

  task automatic build_stream();
    for (int s = 0; s < STAGES; s++)
      for (int sl = 0; sl < 5; sl++) begin
        q.push_back('{1'b1, 32'(s*8 + sl), 1'b1, 1'b0});
        q.push_back('{1'b1, 32'h8000_0000 | 32'(tx_val(mbank[s][sl], sl)), 1'b1, 1'b0});
        q.push_back('{1'b0, 32'd0, 1'b1, 1'b0});
      end
    for (int s = 0; s < STAGES; s++) begin
      q.push_back('{1'b1, 32'(s*8 + 7), 1'b1, 1'b0});
      q.push_back('{1'b1, 32'h8000_0000, 1'b1, 1'b0});
      q.push_back('{1'b0, 32'd0, 1'b1, 1'b0});
    end
    q.push_back('{1'b0, 32'd0, 1'b0, 1'b1});
  endtask

  // Reference model: advances one cycle per rising edge using the inputs seen at that edge.
  initial forever begin
    @(posedge clk);
    if (wrEnable && !cur.busy && int'(wrStage) < STAGES && wrIndex <= 3'd4)
      mbank[wrStage][wrIndex] = wrData;
    if (rst) begin
      q.delete();
      cur = '0;
      model_live = 1'b1;
    end else begin
      if (q.size() == 0 && !cur.done && start) build_stream();
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
    end
  end

  // Stream compare against the model every cycle.
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      vectors++;
      if (csrStrobe !== cur.strobe || GPIO_OUT !== cur.gpio || busy !== cur.busy || done !== cur.done) begin
        miscompares++;
        $display("FAIL stream t=%0t got strobe=%b gpio=%h busy=%b done=%b want strobe=%b gpio=%h busy=%b done=%b",
                 $time, csrStrobe, GPIO_OUT, busy, done, cur.strobe, cur.gpio, cur.busy, cur.done);
      end
    end
  end

  // Filter-side CSR decoder: address word selects stage/slot, data lands in shadow, slot 7 commits.
  logic [CW-1:0] shadow    [8][5];
  logic [CW-1:0] committed [8][5];
  logic [31:0]   pend_addr = 32'd0;
  int            commit_count = 0;
  initial begin
    for (int s = 0; s < 8; s++)
      for (int sl = 0; sl < 5; sl++) begin
        shadow[s][sl]    = '0;
        committed[s][sl] = '0;
      end
  end
  initial forever begin
    @(negedge clk);
    if (csrStrobe === 1'b1) begin
      if (GPIO_OUT[31] == 1'b0) pend_addr = GPIO_OUT;
      else if (pend_addr[2:0] == 3'd7) begin
        for (int sl = 0; sl < 5; sl++) committed[pend_addr[5:3]][sl] = shadow[pend_addr[5:3]][sl];
        commit_count++;
      end else if (pend_addr[2:0] <= 3'd4) begin
        shadow[pend_addr[5:3]][pend_addr[2:0]] = GPIO_OUT[CW-1:0];
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int i, input logic [CW-1:0] d);
    wrEnable = 1'b1;
    wrStage  = 3'(s);
    wrIndex  = 3'(i);
    wrData   = d;
    step();
    wrEnable = 1'b0;
  endtask

  task automatic run_plain();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (39) step();
    @(negedge clk);
    step();
  endtask

  // Unity-gain stream with ignored start pulses at 5 and 37 and a dropped write at 10.
  task automatic unity_run(input string tag);
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      start    = (k == 5 || k == 37);
      wrEnable = (k == 10);
      wrStage  = 3'd0;
      wrIndex  = 3'd0;
      wrData   = 25'h0000123;
      @(negedge clk);
      case (k)
        1: begin
          check_lit({tag, " k1 gpio"}, GPIO_OUT, 32'h0000_0000);
          check_lit({tag, " k1 strobe"}, 32'(csrStrobe), 32'd1);
          check_lit({tag, " k1 busy"}, 32'(busy), 32'd1);
        end
        2:  check_lit({tag, " k2 gpio"}, GPIO_OUT, 32'h8040_0000);
        4:  check_lit({tag, " k4 gpio"}, GPIO_OUT, 32'h0000_0001);
        5:  check_lit({tag, " k5 gpio"}, GPIO_OUT, 32'h8000_0000);
        6:  check_lit({tag, " k6 strobe"}, 32'(csrStrobe), 32'd0);
        16: check_lit({tag, " k16 gpio"}, GPIO_OUT, 32'h0000_0008);
        17: check_lit({tag, " k17 gpio"}, GPIO_OUT, 32'h8040_0000);
        19: check_lit({tag, " k19 gpio"}, GPIO_OUT, 32'h0000_0009);
        31: check_lit({tag, " k31 gpio"}, GPIO_OUT, 32'h0000_0007);
        32: check_lit({tag, " k32 gpio"}, GPIO_OUT, 32'h8000_0000);
        34: check_lit({tag, " k34 gpio"}, GPIO_OUT, 32'h0000_000F);
        36: check_lit({tag, " k36 busy"}, 32'(busy), 32'd1);
        37: begin
          check_lit({tag, " k37 done"}, 32'(done), 32'd1);
          check_lit({tag, " k37 busy"}, 32'(busy), 32'd0);
        end
        38: begin
          check_lit({tag, " k38 busy"}, 32'(busy), 32'd0);
          check_lit({tag, " k38 done"}, 32'(done), 32'd0);
        end
        default: ;
      endcase
    end
    step();
  endtask

  logic [CW-1:0] rv0, rv1;
  int            c0;

  initial begin
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check_lit("reset busy", 32'(busy), 32'd0);
    check_lit("reset done", 32'(done), 32'd0);
    check_lit("reset strobe", 32'(csrStrobe), 32'd0);
    check_lit("reset gpio", GPIO_OUT, 32'd0);
    step();

    // Unity bank plus illegal writes that must be dropped.
    for (int s = 0; s < STAGES; s++)
      for (int sl = 0; sl < 5; sl++) wr(s, sl, (sl == 0) ? 25'h0400000 : 25'h0000000);
    wr(2, 0, 25'h1555555);
    wr(0, 6, 25'h0AAAAAA);
    wr(7, 4, 25'h1234567);
    unity_run("unity");
    unity_run("readback");

    // First-order bank checked through the filter decoder.
    wr(0, 0, 25'h00CCCCC);
    wr(0, 4, 25'h01CCCCD);
    run_plain();
    check_lit("fo s0b0", 32'(committed[0][0]), 32'h000C_CCCC);
    check_lit("fo s0b1", 32'(committed[0][1]), 32'h0000_0000);
    check_lit("fo s0a2", 32'(committed[0][3]), 32'h0000_0000);
`ifdef COEF_LOADER_NEGATE_A_EN
    check_lit("fo s0a1", 32'(committed[0][4]), 32'h01E3_3333);
`else
    check_lit("fo s0a1", 32'(committed[0][4]), 32'h001C_CCCD);
`endif
    check_lit("fo s1b0", 32'(committed[1][0]), 32'h0040_0000);

`ifdef COEF_LOADER_NEGATE_A_EN
    wr(1, 4, 25'h07FCB05);
    wr(1, 3, 25'h1000000);
    run_plain();
    check_lit("neg a1", 32'(committed[1][4]), 32'h0180_34FB);
    check_lit("neg sat", 32'(committed[1][3]), 32'h00FF_FFFF);
    wr(1, 4, 25'h0000000);
    wr(1, 3, 25'h0000000);
`endif

    // Reset mid-transmission: no commits, no done, then a clean reload.
    rv0 = CW'($urandom);
    rv1 = CW'($urandom);
    wr(0, 0, rv0);
    wr(1, 2, rv1);
    c0 = commit_count;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      start = 1'b0;
      rst   = (k == 20);
      @(negedge clk);
      if (k == 21) begin
        check_lit("rst strobe", 32'(csrStrobe), 32'd0);
        check_lit("rst gpio", GPIO_OUT, 32'd0);
        check_lit("rst busy", 32'(busy), 32'd0);
      end
      if (k >= 21) check_lit($sformatf("rst nodone k%0d", k), 32'(done), 32'd0);
    end
    step();
    check_lit("rst commits", 32'(commit_count), 32'(c0));
    check_lit("rst kept", 32'(committed[0][0]), 32'h000C_CCCC);
    run_plain();
    check_lit("reload s0b0", 32'(committed[0][0]), 32'(rv0));
    check_lit("reload s1b2", 32'(committed[1][2]), 32'(rv1));
    check_lit("reload commits", 32'(commit_count), 32'(c0 + 2));

    // Random traffic checked by the model stream compare.
    repeat (3000) begin
      step();
      wrEnable = ($urandom_range(0, 2) == 0);
      wrStage  = 3'($urandom_range(0, 3));
      wrIndex  = 3'($urandom_range(0, 7));
      wrData   = CW'($urandom);
      start    = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 299) == 0);
    end
    step();
    wrEnable = 1'b0;
    start    = 1'b0;
    rst      = 1'b0;
    repeat (45) step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
